// File: rtl/common_pkg.sv
// Shared definitions for the instruction-fetch memory side: default SRAM
// address width, reset PC, the responder FSM state type and the helpers
// that decide how a fetched word turns into an instruction.
package common;

   localparam int MEM_AW_DEF = 12;
   localparam logic [31:0] PC_INIT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      RD_LO,
      RD_HI,
      RESP
   } imem_state_t;

   // Outcome of looking at the first SRAM word of a fetch.
   // straddle: a 32-bit instruction starts in the upper halfword, so the
   // next word is needed. data/is_c are only meaningful when !straddle.
   typedef struct packed {
      logic        straddle;
      logic        is_c;
      logic [31:0] data;
   } lo_decision_t;

   // A halfword opens a compressed instruction unless its low two bits are 11.
   function automatic logic is_rvc(input logic [15:0] halfword);
      return (halfword & 16'h0003) != 16'h0003;
   endfunction

   // Decide what the first word yields, given which halfword the PC selects.
   function automatic lo_decision_t decode_lo(input logic [31:0] word,
                                              input logic        upper);
      lo_decision_t d;
      logic [15:0]  first_half;
      first_half = upper ? word[31:16] : word[15:0];
      d.is_c     = is_rvc(first_half);
      d.straddle = upper && !d.is_c;
      if (d.is_c) begin
         d.data = {16'h0000, first_half};
      end else begin
         d.data = word;
      end
      return d;
   endfunction

endpackage

// File: rtl/imem_word_buf.sv
// One-entry buffer remembering the last word the SRAM returned, so a fetch
// that lands in the same word again can skip the SRAM read. Only built when
// IMEM_WORD_BUF_EN is defined.
module imem_word_buf
   import common::*;
#(
   parameter int MEM_AW = MEM_AW_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [MEM_AW-1:0] wr_idx,
   input  logic [31:0]       wr_data,
   input  logic [MEM_AW-1:0] rd_idx,
   output logic              hit,
   output logic [31:0]       rd_data
);

   logic              valid;
   logic [MEM_AW-1:0] idx;
   logic [31:0]       data;

   // Capture every SRAM return; reset invalidates the entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid <= 1'b0;
         idx   <= '0;
         data  <= '0;
      end else if (wr_en) begin
         valid <= 1'b1;
         idx   <= wr_idx;
         data  <= wr_data;
      end
   end

   assign hit     = valid && (idx == rd_idx);
   assign rd_data = data;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: takes the fetch stage's level request,
// reads a word-organised 1-cycle-latency SRAM (twice when a 32-bit
// instruction straddles two words) and returns a registered instruction
// with a one-cycle imem_resp pulse.
// Optional feature macro: IMEM_WORD_BUF_EN adds a last-word buffer that
// lets repeat fetches into the same word skip the first SRAM read.
module imem_responder
   import common::*;
#(
   parameter int MEM_AW = MEM_AW_DEF,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              imem_req,
   input  logic [PC_W-1:0]   imem_req_addr,
   output logic [31:0]       imem_data,
   output logic              imem_resp,
   output logic              is_compress,
   output logic              mem_rd_en,
   output logic [MEM_AW-1:0] mem_rd_addr,
   input  logic [31:0]       mem_rd_data
);

   imem_state_t       state, state_nxt;
   logic [MEM_AW-1:0] cap_idx, cap_idx_nxt;
   logic              cap_hi, cap_hi_nxt;
   logic [15:0]       held, held_nxt;
   logic [31:0]       data_nxt;
   logic              comp_nxt;
   logic              resp_nxt;
   lo_decision_t      dec;

   logic [MEM_AW-1:0] req_idx;
   logic              req_hi;
   logic              unused_addr_bits;

   assign req_idx          = imem_req_addr[MEM_AW+1:2];
   assign req_hi           = imem_req_addr[1];
   assign unused_addr_bits = ^{imem_req_addr[PC_W-1:MEM_AW+2], imem_req_addr[0]};

`ifdef IMEM_WORD_BUF_EN
   logic              buf_hit;
   logic [31:0]       buf_data;
   logic              buf_wr_en;
   logic [MEM_AW-1:0] buf_wr_idx;
   lo_decision_t      hit_dec;

   imem_word_buf #(
      .MEM_AW (MEM_AW)
   ) u_word_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (buf_wr_en),
      .wr_idx  (buf_wr_idx),
      .wr_data (mem_rd_data),
      .rd_idx  (req_idx),
      .hit     (buf_hit),
      .rd_data (buf_data)
   );
`endif

   // State, captured request and registered response outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         cap_idx     <= '0;
         cap_hi      <= 1'b0;
         held        <= '0;
         imem_data   <= '0;
         is_compress <= 1'b0;
         imem_resp   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cap_idx     <= cap_idx_nxt;
         cap_hi      <= cap_hi_nxt;
         held        <= held_nxt;
         imem_data   <= data_nxt;
         is_compress <= comp_nxt;
         imem_resp   <= resp_nxt;
      end
   end

   // Next state, SRAM read strobe/address and the values to register.
   // imem_resp is loaded on the transition into RESP, so it is high exactly
   // during the RESP cycle. Once captured, a request runs to completion off
   // cap_idx/cap_hi regardless of what imem_req does afterwards.
   always_comb begin
      state_nxt   = state;
      cap_idx_nxt = cap_idx;
      cap_hi_nxt  = cap_hi;
      held_nxt    = held;
      data_nxt    = imem_data;
      comp_nxt    = is_compress;
      resp_nxt    = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      dec         = decode_lo(mem_rd_data, cap_hi);
`ifdef IMEM_WORD_BUF_EN
      buf_wr_en   = 1'b0;
      buf_wr_idx  = cap_idx;
      hit_dec     = decode_lo(buf_data, req_hi);
`endif

      case (state)
         IDLE: begin
            if (imem_req) begin
               cap_idx_nxt = req_idx;
               cap_hi_nxt  = req_hi;
`ifdef IMEM_WORD_BUF_EN
               if (buf_hit) begin
                  if (hit_dec.straddle) begin
                     held_nxt    = buf_data[31:16];
                     mem_rd_en   = 1'b1;
                     mem_rd_addr = req_idx + MEM_AW'(1);
                     state_nxt   = RD_HI;
                  end else begin
                     data_nxt  = hit_dec.data;
                     comp_nxt  = hit_dec.is_c;
                     resp_nxt  = 1'b1;
                     state_nxt = RESP;
                  end
               end else begin
                  mem_rd_en   = 1'b1;
                  mem_rd_addr = req_idx;
                  state_nxt   = RD_LO;
               end
`else
               mem_rd_en   = 1'b1;
               mem_rd_addr = req_idx;
               state_nxt   = RD_LO;
`endif
            end
         end

         RD_LO: begin
`ifdef IMEM_WORD_BUF_EN
            buf_wr_en  = 1'b1;
            buf_wr_idx = cap_idx;
`endif
            if (dec.straddle) begin
               held_nxt    = mem_rd_data[31:16];
               mem_rd_en   = 1'b1;
               mem_rd_addr = cap_idx + MEM_AW'(1);
               state_nxt   = RD_HI;
            end else begin
               data_nxt  = dec.data;
               comp_nxt  = dec.is_c;
               resp_nxt  = 1'b1;
               state_nxt = RESP;
            end
         end

         RD_HI: begin
`ifdef IMEM_WORD_BUF_EN
            buf_wr_en  = 1'b1;
            buf_wr_idx = cap_idx + MEM_AW'(1);
`endif
            data_nxt  = {mem_rd_data[15:0], held};
            comp_nxt  = 1'b0;
            resp_nxt  = 1'b1;
            state_nxt = RESP;
         end

         RESP: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: SRAM model, reference fetch model
// working on halfwords of the memory image, directed cases then random
// requests. Follows IMEM_WORD_BUF_EN if defined for the build.
module tb_imem_responder;

   localparam int MEM_AW = 12;
   localparam int PC_W   = 32;
   localparam int DEPTH  = 1 << MEM_AW;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              imem_req;
   logic [PC_W-1:0]   imem_req_addr;
   logic [31:0]       imem_data;
   logic              imem_resp;
   logic              is_compress;
   logic              mem_rd_en;
   logic [MEM_AW-1:0] mem_rd_addr;
   logic [31:0]       mem_rd_data;

   logic [31:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;

   bit model_buf_valid = 1'b0;
   int model_buf_idx   = 0;

   imem_responder #(
      .MEM_AW (MEM_AW),
      .PC_W   (PC_W)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req      (imem_req),
      .imem_req_addr (imem_req_addr),
      .imem_data     (imem_data),
      .imem_resp     (imem_resp),
      .is_compress   (is_compress),
      .mem_rd_en     (mem_rd_en),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_data   (mem_rd_data)
   );

   always #5 clk = ~clk;

   // Synchronous-read SRAM, one cycle of latency.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference: read the instruction as halfwords straight from the image.
   function automatic void refFetch(input logic [31:0] addr,
                                    output logic [31:0] data,
                                    output logic comp,
                                    output bit straddle,
                                    output int idx);
      logic [31:0] lo;
      logic [15:0] first, second;
      idx    = int'((addr >> 2) & (DEPTH - 1));
      lo     = mem[idx];
      first  = addr[1] ? lo[31:16] : lo[15:0];
      second = addr[1] ? mem[(idx + 1) % DEPTH][15:0] : lo[31:16];
      comp   = (first[1:0] != 2'b11);
      straddle = addr[1] && !comp;
      data   = comp ? {16'h0000, first} : {second, first};
   endfunction

   task automatic doReset();
      @(negedge clk);
      reset_n       = 1'b0;
      imem_req      = 1'b0;
      imem_req_addr = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_resp",   imem_resp,   0);
      checkOutput("rst_comp",   is_compress, 0);
      checkOutput("rst_data",   imem_data,   0);
      checkOutput("rst_rd_en",  mem_rd_en,   0);
      checkOutput("rst_rd_addr", mem_rd_addr, 0);
      reset_n         = 1'b1;
      model_buf_valid = 1'b0;
   endtask

   // One fetch: drive the request, count cycles to imem_resp, record SRAM
   // reads, then compare against the reference. flush drops imem_req right
   // after capture; the address is always scrambled after capture.
   task automatic applyStimulus(input logic [31:0] addr, input bit flush);
      logic [31:0]       exp_data;
      logic              exp_comp;
      bit                strad, hit;
      int                idx, exp_lat, exp_reads, lat, reads;
      logic [MEM_AW-1:0] last_rd, exp_last;

      refFetch(addr, exp_data, exp_comp, strad, idx);
`ifdef IMEM_WORD_BUF_EN
      hit = model_buf_valid && (model_buf_idx == idx);
`else
      hit = 1'b0;
`endif
      exp_lat   = (hit ? 1 : 2) + (strad ? 1 : 0);
      exp_reads = (hit ? 0 : 1) + (strad ? 1 : 0);
      exp_last  = strad ? MEM_AW'((idx + 1) % DEPTH) : MEM_AW'(idx);

      @(negedge clk);
      imem_req      = 1'b1;
      imem_req_addr = addr;
      #1;
      reads   = 0;
      lat     = 0;
      last_rd = '0;
      if (mem_rd_en) begin
         reads++;
         last_rd = mem_rd_addr;
      end
      while (lat < 8) begin
         @(posedge clk);
         #1;
         if (lat == 0) begin
            imem_req_addr = $urandom;
            if (flush) imem_req = 1'b0;
         end
         @(negedge clk);
         lat++;
         if (mem_rd_en) begin
            reads++;
            last_rd = mem_rd_addr;
         end
         if (imem_resp) break;
      end

      checkOutput("latency",  lat,         exp_lat);
      checkOutput("data",     imem_data,   exp_data);
      checkOutput("compress", is_compress, exp_comp);
      checkOutput("reads",    reads,       exp_reads);
      if (exp_reads > 0) checkOutput("rd_addr", last_rd, exp_last);

      imem_req = 1'b0;
      @(negedge clk);
      checkOutput("resp_pulse", imem_resp, 0);

      if (!hit || strad) begin
         model_buf_valid = 1'b1;
         model_buf_idx   = strad ? (idx + 1) % DEPTH : idx;
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      imem_req      = 1'b0;
      imem_req_addr = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[0]         = 32'h0050_0093;
      mem[1]         = 32'h4585_4505;
      mem[2]         = 32'h0093_1234;
      mem[3]         = 32'h5678_0050;
      mem[DEPTH - 1] = 32'hABC3_1111;

      doReset();

      // Directed cases from the fetch scenarios.
      applyStimulus(32'h0000_0000, 1'b0);
      applyStimulus(32'h0000_0004, 1'b0);
      applyStimulus(32'h0000_0006, 1'b0);
      applyStimulus(32'h0000_0004, 1'b0);
      applyStimulus(32'h0000_000A, 1'b0);
      applyStimulus(32'h0000_3FFE, 1'b0);
      applyStimulus(32'h0000_000A, 1'b1);
      applyStimulus(32'h8000_0002, 1'b1);
      applyStimulus(32'h0000_0004, 1'b0);
      applyStimulus(32'h0000_0004, 1'b0);

      // Reset while the second straddle read is in flight.
      doReset();
      @(negedge clk);
      imem_req      = 1'b1;
      imem_req_addr = 32'h0000_000A;
      @(negedge clk);
      imem_req = 1'b0;
      checkOutput("abort_rd_en",   mem_rd_en,   1);
      checkOutput("abort_rd_addr", mem_rd_addr, 3);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_resp",    imem_resp,   0);
      checkOutput("abort_data",    imem_data,   0);
      checkOutput("abort_comp",    is_compress, 0);
      checkOutput("abort_rd_en2",  mem_rd_en,   0);
      checkOutput("abort_rd_adr2", mem_rd_addr, 0);
      reset_n         = 1'b1;
      model_buf_valid = 1'b0;
      begin
         int seen;
         seen = 0;
         repeat (4) begin
            @(negedge clk);
            if (imem_resp) seen++;
         end
         checkOutput("abort_no_resp", seen, 0);
      end

      // Random fetches, biased towards a few words and the top of memory.
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         int          mode;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       a = $urandom;
            1, 2:    a = 32'($urandom_range(0, 23));
            default: a = 32'h0000_3FF0 + 32'($urandom_range(0, 15));
         endcase
         applyStimulus(a, ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
